// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment display path: segment bit positions,
// the hex glyph table and the scan slot states.
package seven_seg_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   localparam logic [7:0] SEGS_OFF = 8'h00;

   // Active-high a-g patterns, entry [n] is hex digit n (bit0 = a)
   localparam logic [15:0][6:0] HEX_SEGS = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef enum logic {
      SLOT_BLANK = 1'b0,
      SLOT_SHOW  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/seven_seg_scan_mux_hex_to_7seg.sv
// Hex nibble to active-high segment pattern; dp bit is left clear for the caller.
module hex_to_7seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] i_val,
   output logic [7:0] o_seg_vals
);

   assign o_seg_vals = {1'b0, HEX_SEGS[i_val]};

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Four-digit multiplexed 7-seg driver with per-slot blanking, frame-aligned
// value updates and optional leading-zero suppression.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   SLOT_BLANK | leading cycles of a digit slot, all digits off
//   SLOT_SHOW  | remainder of the slot, digit dig lit
module seven_seg_scan_mux
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 4000,
   parameter int BLANK_CYCLES   = 16,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [4*NUM_DIGITS-1:0] i_val,
   input  logic [NUM_DIGITS-1:0]   i_dp,
   input  logic                    i_lz_blank,
   input  logic                    i_load,
   output logic [7:0]              o_seg,
   output logic [NUM_DIGITS-1:0]   o_dig,
   output logic                    o_frame
);

   localparam int CW  = $clog2(SCAN_DIV);
   localparam int DGW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);
   localparam logic [7:0]    SEG_IDLE  = (SEG_ACTIVE_LOW != 0) ? ~SEGS_OFF : SEGS_OFF;
   localparam logic [NUM_DIGITS-1:0] DIG_IDLE = {NUM_DIGITS{DIG_ACTIVE_LOW != 0}};

   logic [CW-1:0]           cnt, cnt_nxt;
   logic [DGW-1:0]          dig, dig_nxt;
   logic [4*NUM_DIGITS-1:0] pend_val, act_val, act_val_nxt, upper_nxt;
   logic [NUM_DIGITS-1:0]   pend_dp, act_dp, act_dp_nxt;
   logic                    pend_lz, act_lz, act_lz_nxt, pend_flag;
   logic                    wrap, take;
   slot_state_t             state, state_nxt;
   logic [7:0]              dec_seg, seg_nxt;
   logic [NUM_DIGITS-1:0]   dig_nxt_out;
   logic                    frame_q;

   assign wrap    = (cnt == CNT_MAX);
   assign cnt_nxt = wrap ? '0 : cnt + 1'b1;
   assign dig_nxt = wrap ? dig + 1'b1 : dig;
   assign take    = wrap && (dig == DGW'(NUM_DIGITS - 1)) && pend_flag;

   assign act_val_nxt = take ? pend_val : act_val;
   assign act_dp_nxt  = take ? pend_dp  : act_dp;
   assign act_lz_nxt  = take ? pend_lz  : act_lz;
   assign state_nxt   = (cnt_nxt < BLANK_CNT) ? SLOT_BLANK : SLOT_SHOW;

   // Nibbles from the current digit upward; all-zero means it is a leading zero
   assign upper_nxt = act_val_nxt >> {dig_nxt, 2'b00};

   hex_to_7seg u_hex_to_7seg (
      .i_val      (upper_nxt[3:0]),
      .o_seg_vals (dec_seg)
   );

   always_comb begin
      seg_nxt     = SEGS_OFF;
      dig_nxt_out = '0;
      if (state_nxt == SLOT_SHOW) begin
         if (!(act_lz_nxt && (dig_nxt != '0) && (upper_nxt == '0)))
            seg_nxt = dec_seg;
         seg_nxt[SEG_DP] = act_dp_nxt[dig_nxt];
         dig_nxt_out     = NUM_DIGITS'(1) << dig_nxt;
      end
      if (SEG_ACTIVE_LOW != 0) seg_nxt     = ~seg_nxt;
      if (DIG_ACTIVE_LOW != 0) dig_nxt_out = ~dig_nxt_out;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt       <= '0;
         dig       <= '0;
         pend_val  <= '0;
         pend_dp   <= '0;
         pend_lz   <= 1'b0;
         pend_flag <= 1'b0;
         act_val   <= '0;
         act_dp    <= '0;
         act_lz    <= 1'b0;
         state     <= SLOT_BLANK;
         o_seg     <= SEG_IDLE;
         o_dig     <= DIG_IDLE;
         frame_q   <= 1'b1;
      end else begin
         cnt     <= cnt_nxt;
         dig     <= dig_nxt;
         act_val <= act_val_nxt;
         act_dp  <= act_dp_nxt;
         act_lz  <= act_lz_nxt;
         if (i_load) begin
            pend_val  <= i_val;
            pend_dp   <= i_dp;
            pend_lz   <= i_lz_blank;
            pend_flag <= 1'b1;
         end else if (take) begin
            pend_flag <= 1'b0;
         end
         state   <= state_nxt;
         o_seg   <= seg_nxt;
         o_dig   <= dig_nxt_out;
         frame_q <= (cnt_nxt == '0) && (dig_nxt == '0);
      end
   end

   // The register sits at 1 through reset so the first cycle after release
   // is marked, while the pin itself stays low as long as RST is held.
   assign o_frame = frame_q & ~RST;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Scoreboard bench for seven_seg_scan_mux with a frame-level reference model.
module tb_seven_seg_scan_mux;

   localparam int SD = 8;
   localparam int BC = 2;
   localparam int FR = 4 * SD;
   localparam bit [6:0] HEX_TAB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef struct {
      int          cyc;
      logic [15:0] v;
      logic [3:0]  dp;
      logic        lz;
   } load_t;

   typedef struct {
      int         dig;
      logic [7:0] seg;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] i_val;
   logic [3:0]  i_dp;
   logic        i_lz_blank;
   logic        i_load;
   logic [7:0]  o_seg;
   logic [3:0]  o_dig;
   logic        o_frame;

   load_t log_q[$];
   exp_t  sb_q[$];
   exp_t  cur;
   int    checks = 0;
   int    errors = 0;
   int    cyc;
   bit    checking = 1'b0;
   bit    prev_act = 1'b0;

   seven_seg_scan_mux #(
      .NUM_DIGITS     (4),
      .SCAN_DIV       (SD),
      .BLANK_CYCLES   (BC),
      .SEG_ACTIVE_LOW (0),
      .DIG_ACTIVE_LOW (1)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .i_val      (i_val),
      .i_dp       (i_dp),
      .i_lz_blank (i_lz_blank),
      .i_load     (i_load),
      .o_seg      (o_seg),
      .o_dig      (o_dig),
      .o_frame    (o_frame)
   );

   always #5 CLK = ~CLK;

   // Cycle index since the last reset release
   always @(posedge CLK or posedge RST) begin
      if (RST) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_seg(input load_t a, input int k);
      logic [15:0] upper;
      logic        hide;
      upper = a.v >> (4 * k);
      hide  = a.lz && (k > 0) && (upper == 16'h0);
      return {a.dp[k], hide ? 7'h00 : HEX_TAB[upper[3:0]]};
   endfunction

   // The value a frame shows is the last load sampled strictly before its
   // boundary edge; a load on the boundary edge itself waits a frame.
   function automatic load_t active_for(input int n);
      load_t r;
      r.cyc = 0; r.v = '0; r.dp = '0; r.lz = 1'b0;
      foreach (log_q[i])
         if (log_q[i].cyc <= FR * n - 2) r = log_q[i];
      return r;
   endfunction

   function automatic int idx_of(input logic [3:0] d);
      for (int i = 0; i < 4; i++)
         if (d[i] == 1'b0) return i;
      return -1;
   endfunction

   always @(negedge CLK) begin
      load_t a;
      exp_t  e;
      if (checking && !RST && (cyc % FR == 0)) begin
         a = active_for(cyc / FR);
         for (int k = 0; k < 4; k++) begin
            e.dig = k;
            e.seg = exp_seg(a, k);
            sb_q.push_back(e);
         end
      end
   end

   always @(negedge CLK) begin
      logic [3:0] exp_dig;
      if (!checking || RST) begin
         prev_act = 1'b0;
      end else begin
         chk("frame", 32'(o_frame), 32'(cyc % FR == 0));
         exp_dig = ((cyc % SD) < BC) ? 4'hF : ~(4'b0001 << ((cyc / SD) % 4));
         chk("dig_timing", 32'(o_dig), 32'(exp_dig));
         if (o_dig != 4'hF) begin
            if (!prev_act) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL scoreboard_underflow cyc=%0d got=%0h expected=entry", cyc, o_dig);
               end else begin
                  cur = sb_q.pop_front();
                  chk("dig_index", 32'(idx_of(o_dig)), 32'(cur.dig));
               end
            end
            chk("seg_show", 32'(o_seg), 32'(cur.seg));
         end else begin
            chk("seg_blank", 32'(o_seg), 32'h0);
         end
         prev_act = (o_dig != 4'hF);
      end
   end

   task automatic wait_until(input int c);
      int g;
      g = 0;
      while (cyc < c && g < 20000) begin
         @(posedge CLK);
         #1;
         g++;
      end
      if (cyc != c) begin
         checks++;
         errors++;
         $display("FAIL wait_cycle got=%0d expected=%0d", cyc, c);
      end
   endtask

   task automatic load_at(input int c, input logic [15:0] v, input logic [3:0] dp, input logic lz);
      load_t l;
      wait_until(c);
      i_val      = v;
      i_dp       = dp;
      i_lz_blank = lz;
      i_load     = 1'b1;
      l.cyc = cyc; l.v = v; l.dp = dp; l.lz = lz;
      log_q.push_back(l);
      @(posedge CLK);
      #1;
      i_load = 1'b0;
   endtask

   initial begin
      int          c;
      int          base;
      logic [15:0] v;
      i_val = '0; i_dp = '0; i_lz_blank = 1'b0; i_load = 1'b0;
      RST = 1'b0;
      #1 RST = 1'b1;
      #11;
      chk("rst_dig", 32'(o_dig), 32'hF);
      chk("rst_seg", 32'(o_seg), 32'h0);
      chk("rst_frame", 32'(o_frame), 32'h0);
      @(posedge CLK);
      #2;
      RST = 1'b0;
      checking = 1'b1;

      load_at(10,  16'h1234, 4'b0100, 1'b0);
      load_at(40,  16'h00A0, 4'b0000, 1'b1);
      load_at(70,  16'h1111, 4'b1111, 1'b0);
      load_at(80,  16'h2222, 4'b0001, 1'b0);
      load_at(100, 16'h1234, 4'b0100, 1'b0);
      load_at(127, 16'hBEEF, 4'b1000, 1'b0);

      c = 6 * FR;
      for (int i = 0; i < 10; i++) begin
         c += $urandom_range(30, 3);
         v = 16'($urandom);
         case ($urandom_range(3, 0))
            1: v &= 16'h00FF;
            2: v &= 16'h000F;
            3: v = 16'h0000;
            default: ;
         endcase
         load_at(c, v, 4'($urandom), 1'($urandom));
      end

      base = ((cyc / FR) + 2) * FR;
      load_at(base + 3, 16'h5555, 4'hF, 1'b0);
      wait_until(base + 20);
      #2;
      checking = 1'b0;
      RST = 1'b1;
      #1;
      chk("rst_async_dig", 32'(o_dig), 32'hF);
      chk("rst_async_seg", 32'(o_seg), 32'h0);
      chk("rst_async_frame", 32'(o_frame), 32'h0);
      log_q.delete();
      sb_q.delete();
      repeat (3) @(posedge CLK);
      #2;
      RST = 1'b0;
      checking = 1'b1;

      wait_until(3 * FR - 1);
      checking = 1'b0;
      chk("sb_drained", 32'(sb_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_mux.md
Name: seven_seg_scan_mux

Overview:
- Downstream display stage for a 4-digit common-cathode or common-anode 7-seg module on the TinyFPGA BX.
- Takes a 16-bit hex value plus per-digit decimal points, converts each nibble to segments, and time-multiplexes the digits with a blanking gap between them to prevent ghosting.
- Replaces the single-digit direct drive in top. top feeds it counter-derived values and routes o_seg/o_dig to pins.

Parameters:
- NUM_DIGITS, 4, number of scanned digits; fixed at 4 for this revision.
- SCAN_DIV, 4000, clock cycles per digit slot (250 us at 16 MHz); simulation builds use 8.
- BLANK_CYCLES, 16, leading cycles of each slot with all digits off; must satisfy 1 <= BLANK_CYCLES < SCAN_DIV; simulation builds use 2.
- SEG_ACTIVE_LOW, 0, 1 inverts o_seg.
- DIG_ACTIVE_LOW, 1, 1 makes o_dig active-low.

Ports:
- CLK  in  1  16 MHz system clock.
- RST  in  1  asynchronous, active-high reset.
- i_val  in  16  value to display; nibble k is digit k, with digit 0 the least significant (rightmost).
- i_dp  in  4  decimal point per digit, 1 = lit.
- i_lz_blank  in  1  1 = suppress leading zeros.
- i_load  in  1  single-cycle strobe that captures i_val, i_dp and i_lz_blank.
- o_seg  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- o_dig  out  4  digit enables, one-hot or all off, polarity per DIG_ACTIVE_LOW.
- o_frame  out  1  one-cycle pulse at the start of each scan frame.

Behaviour:
- Registers:
  - slot counter cnt, 0..SCAN_DIV-1, width $clog2(SCAN_DIV).
  - digit index dig, 0..3.
  - pending value/dp/lz plus pend_flag.
  - active value/dp/lz.
- Reset (async, takes effect immediately):
  - cnt=0, dig=0, pend_flag=0, all pending and active fields 0.
  - o_dig all inactive, o_seg all segments off (polarity applied), o_frame=0.
- Counting:
  - cnt increments every cycle.
  - At cnt==SCAN_DIV-1, cnt wraps to 0 and dig advances 0,1,2,3,0.
- Per-slot state machine, derived from cnt:
  - BLANK (cnt < BLANK_CYCLES): o_dig all inactive, o_seg all off.
  - SHOW (otherwise): o_dig[dig] active only, o_seg = segments of active nibble dig.
  - BLANK->SHOW at cnt==BLANK_CYCLES. SHOW->BLANK at wrap.
- Output registration:
  - Outputs are registered and computed from the next-state values, so they change on the same edge as cnt/dig. There is no extra latency.
- o_frame:
  - High exactly on cycles where cnt==0 and dig==0.
  - This includes the first cycle after RST deasserts.
  - Period is 4*SCAN_DIV cycles.
- Load:
  - i_load=1 captures the inputs into pending and sets pend_flag.
  - A later load before the frame boundary overwrites pending; last load wins.
- Frame boundary (the edge entering cnt==0, dig==0):
  - If pend_flag=1, active takes pending and pend_flag clears.
  - The new value is shown from digit 0 of that frame, so there is no mid-frame tearing.
- Load on the boundary edge itself:
  - active takes the old pending value.
  - pending takes the new inputs and pend_flag stays 1, so the new value applies at the next boundary.
- Leading-zero blanking (active lz=1):
  - Digit k>0 is blanked (segments a-g off) if nibbles k..3 are all 0.
  - Digit 0 is never blanked.
  - The decimal point is still driven from active dp for blanked digits.
  - o_dig timing is unchanged for blanked digits.
- Decoding:
  - Hex 0-F uses the standard a-g patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71 (active-high, bit0=a).
  - dp is bit 7.
- RST mid-frame: outputs go inactive immediately and the scan restarts at digit 0 with o_frame on the first cycle after release.

Decomposition:
- Shared package seven_seg_pkg holds:
  - the SEG_* bit-position constants (SEG_A..SEG_DP);
  - the 16-entry hex segment table;
  - the SEGS_OFF constant.
- Sub-module: reuse the existing hex_to_7seg (i_val[3:0] -> o_seg_vals[7:0]). It is instantiated once on the muxed nibble; dp is merged in this block.

Test Plan:
- Reset then release, sim params SCAN_DIV=8, BLANK_CYCLES=2:
  - o_frame=1 on the first cycle.
  - o_dig inactive for 2 cycles, then o_dig[0] active for 6 cycles, then 2 blank cycles and digit 1.
  - o_frame repeats every 32 cycles.
- Load 0x1234, dp=4'b0100, lz=0:
  - Nothing changes until the next o_frame.
  - Then, active-high segments: digit0 seg=0x66 ('4'), digit1 0x4F, digit2 0xDB ('2'+dp), digit3 0x06.
- Load 0x00A0 with lz=1:
  - digit3 and digit2 segments a-g off.
  - digit1 0x77, digit0 0x3F.
  - o_dig still steps through all four digits.
- Loads 0x1111 then 0x2222 within one frame: only 0x2222 ever displayed.
- Load 0xBEEF on the boundary edge while 0x1234 is pending:
  - the frame shows 0x1234;
  - the next frame shows 0xBEEF.
- Assert RST during digit 2 SHOW:
  - o_dig and o_seg go inactive asynchronously before the next CLK edge.
  - active clears to 0.
  - After release, the display shows 0x0000 starting at digit 0 with o_frame.
